// File: rtl/nibble_serializer_pkg.sv
// Shared definitions for the nibble serializer: state encoding, default width
// and the counter-width helper.
package nibble_serializer_pkg;

  // State encoding constants
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Default word width in bits (legal range 2..16)
  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT
  } state_e;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// WIDTH-bit parallel-load, shift-right register with zero fill.
// LOAD has priority over SHIFT; nothing changes while ENABLE is low.
module piso_shift_reg
  import nibble_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             LOAD,
  input  logic             SHIFT,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // Parallel load or single-bit right shift on enabled edges
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      Q <= '0;
    end else if (ENABLE) begin
      if (LOAD) begin
        Q <= D;
      end else if (SHIFT) begin
        Q <= {1'b0, Q[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/nibble_serializer.sv
// Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a
// valid/ready handshake and emits it LSB first, one bit per enabled clock,
// with back-to-back words possible on the last-bit cycle.
module nibble_serializer
  import nibble_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [WIDTH-1:0] D_IN,
  input  logic             D_VALID,
  output logic             D_READY,
  output logic             SOUT,
  output logic             SVALID,
  output logic             SLAST,
  output logic             BUSY
);

  localparam int unsigned      CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 16) begin : gen_width_check
    $error("nibble_serializer: WIDTH must be in 2..16");
  end

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             slast_q;
  logic [WIDTH-1:0] sreg_q;
  logic             at_last;
  logic             accept;
  logic             shifting;

  // Only bit 0 drives the line; upper bits just feed the shift chain.
  logic unused_sreg;
  assign unused_sreg = ^sreg_q[WIDTH-1:1];

  // Handshake: ready in IDLE, or on the last bit so the next word follows with no gap
  always_comb begin
    shifting = (state_q == StShift);
    at_last  = shifting && (cnt_q == LAST_CNT);
    D_READY  = ENABLE && !RESET && ((state_q == StIdle) || at_last);
    accept   = D_VALID && D_READY;
  end

  // Data path: load on accept, otherwise shift while a word is in progress.
  // Shifting out the last bit leaves the register at zero, which is the idle value.
  piso_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .ENABLE (ENABLE),
    .LOAD   (accept),
    .SHIFT  (shifting),
    .D      (D_IN),
    .Q      (sreg_q)
  );

  // FSM, bit counter and registered last-bit flag
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      slast_q <= 1'b0;
    end else if (ENABLE) begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StShift;
            cnt_q   <= '0;
            slast_q <= 1'b0;
          end
        end
        StShift: begin
          if (cnt_q != LAST_CNT) begin
            cnt_q   <= cnt_q + CNT_W'(1);
            slast_q <= ((cnt_q + CNT_W'(1)) == LAST_CNT);
          end else if (accept) begin
            cnt_q   <= '0;
            slast_q <= 1'b0;
          end else begin
            state_q <= StIdle;
            cnt_q   <= '0;
            slast_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          slast_q <= 1'b0;
        end
      endcase
    end
  end

  // Serial outputs, all derived directly from registers
  always_comb begin
    SOUT   = sreg_q[0];
    SVALID = shifting;
    BUSY   = shifting;
    SLAST  = slast_q;
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// Self-checking bench for nibble_serializer (WIDTH=4 and WIDTH=8 instances).
// Expected serial bits are queued at stimulus time and popped by a monitor
// on every enabled cycle in which SVALID is high.
module tb_nibble_serializer;

  logic       clk = 1'b0;
  logic       rst;

  logic       en4, dvalid4, dready4, sout4, svalid4, slast4, busy4;
  logic [3:0] din4;
  logic       en8, dvalid8, dready8, sout8, svalid8, slast8, busy8;
  logic [7:0] din8;

  int checks = 0;
  int errors = 0;

  bit exp4_q[$];
  bit exp8_q[$];
  bit e4, e8;

  always #5 clk = ~clk;

  nibble_serializer #(.WIDTH(4)) dut4 (
    .CLOCK   (clk),
    .RESET   (rst),
    .ENABLE  (en4),
    .D_IN    (din4),
    .D_VALID (dvalid4),
    .D_READY (dready4),
    .SOUT    (sout4),
    .SVALID  (svalid4),
    .SLAST   (slast4),
    .BUSY    (busy4)
  );

  nibble_serializer #(.WIDTH(8)) dut8 (
    .CLOCK   (clk),
    .RESET   (rst),
    .ENABLE  (en8),
    .D_IN    (din8),
    .D_VALID (dvalid8),
    .D_READY (dready8),
    .SOUT    (sout8),
    .SVALID  (svalid8),
    .SLAST   (slast8),
    .BUSY    (busy8)
  );

  // Scoreboard monitors: one bit consumed per enabled cycle with SVALID high
  always @(negedge clk) begin
    if (en4 && svalid4) begin
      checks++;
      if (exp4_q.size() == 0) begin
        errors++;
        $display("FAIL mon4_extra_bit: got bit %0b with SVALID=1, required no valid bit", sout4);
      end else begin
        e4 = exp4_q.pop_front();
        if (sout4 !== e4) begin
          errors++;
          $display("FAIL mon4_sout: got %0b, required %0b (t=%0t)", sout4, e4, $time);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (en8 && svalid8) begin
      checks++;
      if (exp8_q.size() == 0) begin
        errors++;
        $display("FAIL mon8_extra_bit: got bit %0b with SVALID=1, required no valid bit", sout8);
      end else begin
        e8 = exp8_q.pop_front();
        if (sout8 !== e8) begin
          errors++;
          $display("FAIL mon8_sout: got %0b, required %0b (t=%0t)", sout8, e8, $time);
        end
      end
    end
  end

  task automatic push4(input logic [3:0] d);
    for (int i = 0; i < 4; i++) exp4_q.push_back(d[i]);
  endtask

  task automatic push8(input logic [7:0] d);
    for (int i = 0; i < 8; i++) exp8_q.push_back(d[i]);
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sout4, svalid4, slast4, busy4} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs4: got %b, required 0000", {sout4, svalid4, slast4, busy4});
    end
    checks++;
    if (dready4 !== 1'b0 || dready8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dready: got %0b/%0b, required 0/0", dready4, dready8);
    end
    checks++;
    if ({sout8, svalid8, slast8, busy8} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs8: got %b, required 0000", {sout8, svalid8, slast8, busy8});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (dready4 !== 1'b1) begin
      errors++;
      $display("FAIL idle_dready: got %0b, required 1", dready4);
    end
  endtask

  task automatic test_single;
    din4 = 4'b1011; dvalid4 = 1'b1; push4(4'b1011);
    @(posedge clk); #1;
    dvalid4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (svalid4 !== 1'b1 || busy4 !== 1'b1) begin
        errors++;
        $display("FAIL single_svalid bit%0d: got %0b%0b, required 11", i, svalid4, busy4);
      end
      checks++;
      if (slast4 !== logic'(i == 3)) begin
        errors++;
        $display("FAIL single_slast bit%0d: got %0b, required %0b", i, slast4, (i == 3));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({sout4, svalid4, slast4, busy4, dready4} !== 5'b00001) begin
      errors++;
      $display("FAIL single_idle: got %b, required 00001",
               {sout4, svalid4, slast4, busy4, dready4});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    din4 = 4'hA; dvalid4 = 1'b1; push4(4'hA); push4(4'h5);
    @(posedge clk); #1;
    din4 = 4'h5;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (svalid4 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_svalid cycle%0d: got %0b, required 1", i, svalid4);
      end
      checks++;
      if (slast4 !== logic'(i == 4 || i == 8)) begin
        errors++;
        $display("FAIL b2b_slast cycle%0d: got %0b, required %0b", i, slast4, (i == 4 || i == 8));
      end
      checks++;
      if (dready4 !== logic'(i == 4 || i == 8)) begin
        errors++;
        $display("FAIL b2b_dready cycle%0d: got %0b, required %0b", i, dready4,
                 (i == 4 || i == 8));
      end
      @(posedge clk); #1;
      if (i == 4) dvalid4 = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (svalid4 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end_svalid: got %0b, required 0", svalid4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall;
    din4 = 4'b0110; dvalid4 = 1'b1; push4(4'b0110);
    @(posedge clk); #1;
    dvalid4 = 1'b0;
    @(posedge clk); #1;
    // bit 1 is on the line; freeze for three cycles while offering a new word
    en4 = 1'b0; dvalid4 = 1'b1; din4 = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({sout4, svalid4, slast4, dready4} !== 4'b1100) begin
        errors++;
        $display("FAIL stall_hold cycle%0d: got sout/svalid/slast/dready=%b, required 1100", i,
                 {sout4, svalid4, slast4, dready4});
      end
      @(posedge clk); #1;
    end
    en4 = 1'b1; dvalid4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (svalid4 !== 1'b1 || slast4 !== logic'(i == 2)) begin
        errors++;
        $display("FAIL stall_resume bit%0d: got svalid/slast=%0b%0b, required 1%0b", i + 1,
                 svalid4, slast4, (i == 2));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({sout4, svalid4} !== 2'b00) begin
      errors++;
      $display("FAIL stall_idle: got %b, required 00", {sout4, svalid4});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    din4 = 4'hF; dvalid4 = 1'b1; push4(4'hF);
    @(posedge clk); #1;
    dvalid4 = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    // bit 2 on the line; reset between edges
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({sout4, svalid4, slast4, busy4, dready4} !== 5'b00000) begin
      errors++;
      $display("FAIL midreset_outputs: got %b, required 00000",
               {sout4, svalid4, slast4, busy4, dready4});
    end
    exp4_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    din4 = 4'h1; dvalid4 = 1'b1; push4(4'h1);
    @(posedge clk); #1;
    dvalid4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (svalid4 !== 1'b1 || slast4 !== logic'(i == 3)) begin
        errors++;
        $display("FAIL midreset_word bit%0d: got svalid/slast=%0b%0b, required 1%0b", i,
                 svalid4, slast4, (i == 3));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (svalid4 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: got %0b, required 0", svalid4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignored;
    din4 = 4'b1001; dvalid4 = 1'b1; push4(4'b1001);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      din4    = 4'(4'h6 + i);
      dvalid4 = (i == 0 || i == 2);
      @(negedge clk);
      checks++;
      if (dready4 !== logic'(i == 3)) begin
        errors++;
        $display("FAIL ignored_dready bit%0d: got %0b, required %0b", i, dready4, (i == 3));
      end
      @(posedge clk); #1;
    end
    dvalid4 = 1'b0;
    @(negedge clk);
    checks++;
    if (svalid4 !== 1'b0) begin
      errors++;
      $display("FAIL ignored_idle: got svalid %0b, required 0", svalid4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width8;
    din8 = 8'h81; dvalid8 = 1'b1; push8(8'h81);
    @(posedge clk); #1;
    dvalid8 = 1'b0; din8 = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (svalid8 !== 1'b1 || slast8 !== logic'(i == 7)) begin
        errors++;
        $display("FAIL w8_flags bit%0d: got svalid/slast=%0b%0b, required 1%0b", i, svalid8,
                 slast8, (i == 7));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if ({sout8, svalid8, slast8, busy8} !== 4'b0000) begin
      errors++;
      $display("FAIL w8_idle: got %b, required 0000", {sout8, svalid8, slast8, busy8});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    en4 = 1'b1; dvalid4 = 1'b0; din4 = '0;
    en8 = 1'b1; dvalid8 = 1'b0; din8 = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_ignored();
    test_width8();
    repeat (2) @(posedge clk);
    checks++;
    if (exp4_q.size() != 0) begin
      errors++;
      $display("FAIL drain4: got %0d bits outstanding, required 0", exp4_q.size());
    end
    checks++;
    if (exp8_q.size() != 0) begin
      errors++;
      $display("FAIL drain8: got %0d bits outstanding, required 0", exp8_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
